// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_multi
// Brief    : NUM_CH independent programmable clock dividers with shadowed,
//            wrap-synchronous divisor updates, global enable and resync.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 26,
    parameter int DEF_DIV = 6250000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              resync,
    input  logic              load,
    input  logic [3:0]        load_ch,
    input  logic [CNT_W-1:0]  load_div,
    input  logic              load_mode,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_def = CNT_W'(DEF_DIV);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [3:0] c_idx = 4'(i);

        logic [CNT_W-1:0] div_q,  div_d;
        logic [CNT_W-1:0] sdiv_q, sdiv_d;
        logic [CNT_W-1:0] cnt_q,  cnt_d;
        logic             mode_q, mode_d;
        logic             smode_q, smode_d;
        logic             pend_q, pend_d;
        logic             clk_out_q, clk_out_d;
        logic             tick_q, tick_d;

        logic             w_load_hit;
        logic             w_div_zero;
        logic             w_wrap;

        // Indices at or above NUM_CH never match, so such loads are dropped.
        assign w_load_hit = load && (load_ch == c_idx);
        assign w_div_zero = (div_q == '0);
        assign w_wrap     = (cnt_q == div_q - c_one);

        always_comb begin
            div_d     = div_q;
            mode_d    = mode_q;
            sdiv_d    = sdiv_q;
            smode_d   = smode_q;
            pend_d    = pend_q;
            cnt_d     = cnt_q;
            clk_out_d = clk_out_q;
            tick_d    = 1'b0;

            if (resync) begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (w_load_hit) begin
                    div_d  = load_div;
                    mode_d = load_mode;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    div_d  = sdiv_q;
                    mode_d = smode_q;
                    pend_d = 1'b0;
                end
            end else if (w_load_hit && w_div_zero) begin
                // A stopped channel has no wrap to wait for.
                div_d     = load_div;
                mode_d    = load_mode;
                pend_d    = 1'b0;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end else begin
                if (w_div_zero) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                end else if (enable) begin
                    if (w_wrap) begin
                        cnt_d     = '0;
                        tick_d    = 1'b1;
                        clk_out_d = mode_q ? 1'b0 : ~clk_out_q;
                        if (pend_q) begin
                            div_d  = sdiv_q;
                            mode_d = smode_q;
                            pend_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
                // A load landing on a wrap edge becomes the next pending value.
                if (w_load_hit) begin
                    sdiv_d  = load_div;
                    smode_d = load_mode;
                    pend_d  = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                div_q     <= c_def;
                mode_q    <= 1'b0;
                sdiv_q    <= '0;
                smode_q   <= 1'b0;
                pend_q    <= 1'b0;
                cnt_q     <= '0;
                clk_out_q <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                div_q     <= div_d;
                mode_q    <= mode_d;
                sdiv_q    <= sdiv_d;
                smode_q   <= smode_d;
                pend_q    <= pend_d;
                cnt_q     <= cnt_d;
                clk_out_q <= clk_out_d;
                tick_q    <= tick_d;
            end
        end

        assign clk_out[i] = clk_out_q;
        assign tick[i]    = tick_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_multi
// Brief    : Directed scenarios plus randomized traffic against a per-channel
//            arithmetic reference model of clk_div_multi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DEFD = 4;
    localparam int HLEN = 1024;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           enable = 1'b0;
    logic           resync = 1'b0;
    logic           load = 1'b0;
    logic [3:0]     load_ch = '0;
    logic [CW-1:0]  load_div = '0;
    logic           load_mode = 1'b0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int m_div[NCH], m_mode[NCH], m_sdiv[NCH], m_smode[NCH];
    int m_pend[NCH], m_cnt[NCH], m_clk[NCH], m_tick[NCH];

    logic [NCH-1:0] hist_tick [0:HLEN-1];
    logic [NCH-1:0] hist_clk  [0:HLEN-1];

    clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DEFD)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .resync    (resync),
        .load      (load),
        .load_ch   (load_ch),
        .load_div  (load_div),
        .load_mode (load_mode),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c] = DEFD; m_mode[c] = 0; m_sdiv[c] = 0; m_smode[c] = 0;
            m_pend[c] = 0;   m_cnt[c] = 0;  m_clk[c] = 0;  m_tick[c] = 0;
        end
    endtask

    // Reference: one rising edge of every channel, straight from the behavioural rules.
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit hit = load && (int'(load_ch) == c);
            m_tick[c] = 0;
            if (resync) begin
                if (m_pend[c] != 0) begin m_div[c] = m_sdiv[c]; m_mode[c] = m_smode[c]; end
                if (hit) begin m_div[c] = int'(load_div); m_mode[c] = int'(load_mode); end
                m_pend[c] = 0; m_cnt[c] = 0; m_clk[c] = 0;
            end else if (hit && m_div[c] == 0) begin
                m_div[c] = int'(load_div); m_mode[c] = int'(load_mode);
                m_pend[c] = 0; m_cnt[c] = 0; m_clk[c] = 0;
            end else begin
                if (m_div[c] == 0) begin
                    m_cnt[c] = 0; m_clk[c] = 0;
                end else if (enable) begin
                    if (m_cnt[c] == m_div[c] - 1) begin
                        m_tick[c] = 1;
                        m_clk[c]  = (m_mode[c] != 0) ? 0 : 1 - m_clk[c];
                        if (m_pend[c] != 0) begin
                            m_div[c] = m_sdiv[c]; m_mode[c] = m_smode[c]; m_pend[c] = 0;
                        end
                    end
                    m_cnt[c] = (m_cnt[c] + 1) % m_div[c];
                    if (m_tick[c] != 0) m_cnt[c] = 0;
                end
                if (hit) begin m_sdiv[c] = int'(load_div); m_smode[c] = int'(load_mode); m_pend[c] = 1; end
            end
        end
    endtask

    function automatic logic [NCH-1:0] m_vec(input bit want_tick);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = want_tick ? (m_tick[c] != 0) : (m_clk[c] != 0);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        cyc++;
        @(negedge clk);
        check_eq("clk_out", 32'(clk_out), 32'(m_vec(1'b0)));
        check_eq("tick", 32'(tick), 32'(m_vec(1'b1)));
        if (cyc < HLEN) begin
            hist_tick[cyc] = tick;
            hist_clk[cyc]  = clk_out;
        end
    endtask

    task automatic do_load(input int ch, input int dv, input bit md);
        load = 1'b1; load_ch = 4'(ch); load_div = CW'(dv); load_mode = md;
        step();
        load = 1'b0;
    endtask

    // Called at a falling edge: reset pulse lands between rising edges.
    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_clk", 32'(clk_out), 32'h0);
        check_eq("async_rst_tick", 32'(tick), 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int r;
        logic [NCH-1:0] exp_t;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("reset_clk", 32'(clk_out), 32'h0);
        check_eq("reset_tick", 32'(tick), 32'h0);
        reset_n = 1'b1;
        enable  = 1'b1;
        cyc     = 0;

        // Default divisor 4 on all channels.
        repeat (13) step();
        for (int k = 1; k <= 12; k++) begin
            check_eq("def_tick", 32'(hist_tick[k]), (k % 4 == 0) ? 32'hF : 32'h0);
            check_eq("def_clk", 32'(hist_clk[k]), ((k / 4) % 2 == 1) ? 32'hF : 32'h0);
        end

        // Ch1 reload 4 -> 10 while its counter is 1.
        do_load(1, 10, 1'b0);
        while (cyc < 40) step();
        check_eq("ld_t16", 32'(hist_tick[16][1]), 32'h1);
        check_eq("ld_t20", 32'(hist_tick[20][1]), 32'h0);
        check_eq("ld_t25", 32'(hist_tick[25][1]), 32'h0);
        check_eq("ld_t26", 32'(hist_tick[26][1]), 32'h1);
        check_eq("ld_t36", 32'(hist_tick[36][1]), 32'h1);
        check_eq("ld_c26", 32'(hist_clk[26][1]), 32'h1);
        check_eq("ld_c35", 32'(hist_clk[35][1]), 32'h1);
        check_eq("ld_c36", 32'(hist_clk[36][1]), 32'h0);

        // Ch2 stopped by divisor 0, then restarted with divisor 3.
        while (cyc < 60) step();
        do_load(2, 0, 1'b0);
        while (cyc < 79) step();
        for (int k = 65; k <= 79; k++) begin
            check_eq("div0_tick", 32'(hist_tick[k][2]), 32'h0);
            check_eq("div0_clk", 32'(hist_clk[k][2]), 32'h0);
        end
        do_load(2, 3, 1'b0);
        while (cyc < 90) step();
        check_eq("restart_t81", 32'(hist_tick[81][2]), 32'h0);
        check_eq("restart_t82", 32'(hist_tick[82][2]), 32'h0);
        check_eq("restart_t83", 32'(hist_tick[83][2]), 32'h1);
        check_eq("restart_c83", 32'(hist_clk[83][2]), 32'h1);

        // Divisors 3,5,3,7, then resync and a 5-cycle enable gap.
        do_load(0, 3, 1'b0);
        do_load(1, 5, 1'b0);
        do_load(3, 7, 1'b0);
        while (cyc < 110) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        r = cyc;
        check_eq("resync_clk", 32'(hist_clk[r]), 32'h0);
        check_eq("resync_tick", 32'(hist_tick[r]), 32'h0);
        while (cyc < r + 9) step();
        enable = 1'b0;
        repeat (5) step();
        enable = 1'b1;
        while (cyc < r + 22) step();
        for (int k = 1; k <= 7; k++) begin
            exp_t[0] = (k == 3 || k == 6);
            exp_t[1] = (k == 5);
            exp_t[2] = (k == 3 || k == 6);
            exp_t[3] = (k == 7);
            check_eq("resync_first", 32'(hist_tick[r + k]), 32'(exp_t));
        end
        for (int k = 10; k <= 14; k++) check_eq("en_off_tick", 32'(hist_tick[r + k]), 32'h0);
        check_eq("en_off_c3", 32'(hist_clk[r + 12][3]), 32'h1);
        check_eq("en_ext_t14", 32'(hist_tick[r + 14][3]), 32'h0);
        check_eq("en_ext_t19", 32'(hist_tick[r + 19][3]), 32'h1);
        check_eq("en_ext_c19", 32'(hist_clk[r + 19][3]), 32'h0);
        check_eq("en_ext_t17", 32'(hist_tick[r + 17][0]), 32'h1);

        // Pending load discarded by an asynchronous reset.
        do_load(0, 9, 1'b0);
        step();
        async_reset();
        while (cyc < 9) step();
        check_eq("post_rst_t3", 32'(hist_tick[3]), 32'h0);
        check_eq("post_rst_t4", 32'(hist_tick[4]), 32'hF);
        check_eq("post_rst_t8", 32'(hist_tick[8]), 32'hF);

        // Randomized traffic, including mode-1 and out-of-range channels.
        for (int n = 0; n < 1500; n++) begin
            enable    = ($urandom_range(0, 9) != 0);
            resync    = ($urandom_range(0, 39) == 0);
            load      = ($urandom_range(0, 4) == 0);
            load_ch   = 4'($urandom_range(0, 5));
            load_div  = CW'($urandom_range(0, 9));
            load_mode = ($urandom_range(0, 3) == 0);
            step();
            if ($urandom_range(0, 299) == 0) begin
                load = 1'b0; resync = 1'b0;
                async_reset();
            end
        end
        load = 1'b0; resync = 1'b0; enable = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 26: width of every divisor and counter.
REQ-003 SHALL have parameter DEF_DIV, default 6250000: divisor loaded into every channel at reset (8 Hz square output from 100 MHz).
REQ-004 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: enable  input  1  global run; low freezes all channels.
REQ-007 SHALL have port: resync  input  1  single-cycle pulse; phase-aligns all channels.
REQ-008 SHALL have port: load  input  1  single-cycle divisor write strobe.
REQ-009 SHALL have port: load_ch  input  4  channel index for the write.
REQ-010 SHALL have port: load_div  input  CNT_W  new divisor value.
REQ-011 SHALL have port: load_mode  input  1  new mode: 0 = square toggle, 1 = tick only.
REQ-012 SHALL have port: clk_out  output  NUM_CH  per-channel divided square wave, registered.
REQ-013 SHALL have port: tick  output  NUM_CH  per-channel one-cycle terminal-count pulse, registered.

Function
REQ-014 Each channel SHALL hold an active divisor DIV, active mode, shadow divisor, shadow mode, shadow-pending flag and a CNT_W-bit counter CNT.
REQ-015 On a clk edge with enable=1 and DIV>0: if CNT==DIV-1 then CNT<=0, tick<=1, clk_out toggles (mode 0) or stays 0 (mode 1); else CNT<=CNT+1, tick<=0.
REQ-016 Tick period SHALL be DIV cycles; clk_out period in mode 0 SHALL be 2*DIV cycles, 50% duty.
REQ-017 DIV=1 SHALL give tick constantly high and clk_out toggling every cycle.
REQ-018 DIV=0 SHALL disable the channel: CNT held 0, tick 0, clk_out 0.
REQ-019 With enable=0, CNT and clk_out SHALL hold and all tick bits SHALL be 0 from the next edge.
REQ-020 A load with load_ch<NUM_CH SHALL write load_div/load_mode to that channel's shadow and set shadow-pending; load_ch>=NUM_CH SHALL be ignored.
REQ-021 A pending shadow SHALL be copied to the active registers on the same edge the channel wraps (CNT==DIV-1), clearing pending; glitch-free period change.
REQ-022 If the channel's active DIV is 0, a load SHALL apply immediately on the load edge (CNT=0, clk_out=0).
REQ-023 A second load before the wrap SHALL overwrite the shadow; only the last value applies.
REQ-024 resync=1 SHALL, on that edge, set every CNT=0, clk_out=0, tick=0, and apply all pending shadows; resync overrides enable=0.
REQ-025 load and resync on the same edge to channel k SHALL apply the new load_div/load_mode to k immediately.
REQ-026 Counter arithmetic SHALL be modulo 2^CNT_W; CNT never exceeds DIV-1 while enabled.

Reset
REQ-027 reset_n=0 SHALL asynchronously force every CNT=0, clk_out=0, tick=0, DIV=DEF_DIV, mode=0, pending=0, regardless of clk.
REQ-028 Reset asserted mid-period SHALL discard any pending shadow; after release counting restarts from CNT=0 on the first rising edge.

Verification
REQ-029 Reset release, DEF_DIV overridden to 4, enable=1 -> tick high on edges 4, 8, 12; clk_out rises at edge 4, falls at edge 8.
REQ-030 Ch1 DIV=4, load ch1 div=10 at CNT=1 -> remaining period stays 4, then tick every 10 cycles, clk_out period 20.
REQ-031 Ch2 loaded div=0 -> clk_out[2]=tick[2]=0 permanently; later load div=3 -> first tick 3 edges after load.
REQ-032 Channels with DIV 3, 5, 7 free-running, pulse resync -> all clk_out=0 next edge, all first ticks at 3, 5, 7 edges after.
REQ-033 enable dropped 5 cycles mid-period -> CNT and clk_out frozen, tick 0; period resumes extended by exactly 5 cycles.
REQ-034 reset_n pulsed low between clk edges with pending load -> outputs 0 immediately, DIV=DEF_DIV, pending value never applied.
